// File: rtl/hls_stage_sequencer.sv
// rtl/hls_stage_sequencer.sv - ap_ctrl_hs controller running enabled loop stages in order
// Records per-stage and total run latency with saturating counters.
module hls_stage_sequencer #(
  parameter int NUM_STAGES = 2,
  parameter int CNT_W      = 32
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        ap_start,
  input  logic [NUM_STAGES-1:0]       stage_en,
  output logic                        ap_done,
  output logic                        ap_ready,
  output logic                        ap_idle,
  output logic [NUM_STAGES-1:0]       stg_start,
  input  logic [NUM_STAGES-1:0]       stg_ready,
  input  logic [NUM_STAGES-1:0]       stg_done,
  output logic [CNT_W-1:0]            last_lat,
  output logic [NUM_STAGES*CNT_W-1:0] stg_lat
);

  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [NUM_STAGES-1:0]   en_q;
  logic [CNT_W-1:0]        run_cnt;
  logic [CNT_W-1:0]        lat_q [NUM_STAGES];
  logic                    first_found;
  logic                    next_found;
  logic [IW-1:0]           first_idx;
  logic [IW-1:0]           next_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_STAGES-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // first_* scans the live mask for acceptance; next_* scans the latched mask above idx
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (!first_found && stage_en[i]) begin
        first_found = 1'b1;
        first_idx   = IW'(i);
      end
      if (!next_found && en_q[i] && (i > int'(idx))) begin
        next_found = 1'b1;
        next_idx   = IW'(i);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
      ap_ready  <= 1'b0;
      stg_start <= '0;
      idx       <= '0;
      en_q      <= '0;
      run_cnt   <= '0;
      last_lat  <= '0;
      for (int i = 0; i < NUM_STAGES; i++) lat_q[i] <= '0;
    end else begin
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ap_start) begin
            en_q    <= stage_en;
            run_cnt <= '0;
            ap_idle <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) lat_q[i] <= '0;
            if (first_found) begin
              idx       <= first_idx;
              stg_start <= onehot(first_idx);
              state     <= LAUNCH;
            end else begin
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
              state    <= DONE;
            end
          end
        end
        LAUNCH, WAIT: begin
          run_cnt    <= sat_inc(run_cnt);
          lat_q[idx] <= sat_inc(lat_q[idx]);
          if (stg_done[idx]) begin
            if (next_found) begin
              idx       <= next_idx;
              stg_start <= onehot(next_idx);
              state     <= LAUNCH;
            end else begin
              stg_start <= '0;
              ap_done   <= 1'b1;
              ap_ready  <= 1'b1;
              state     <= DONE;
            end
          end else if (state == LAUNCH && stg_ready[idx]) begin
            stg_start <= '0;
            state     <= WAIT;
          end
        end
        DONE: begin
          // +1 accounts for the DONE cycle itself
          last_lat <= sat_inc(run_cnt);
          ap_idle  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stg_lat = '0;
    for (int i = 0; i < NUM_STAGES; i++) stg_lat[i*CNT_W +: CNT_W] = lat_q[i];
  end

endmodule

// File: tb/tb_hls_stage_sequencer.sv
// tb/tb_hls_stage_sequencer.sv - randomized scoreboard bench for hls_stage_sequencer
module tb_hls_stage_sequencer;
  localparam int NS  = 2;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic           ap_clk = 1'b0;
  logic           ap_rst;
  logic           ap_start;
  logic [NS-1:0]  stage_en;
  logic           ap_done;
  logic           ap_ready;
  logic           ap_idle;
  logic [NS-1:0]  stg_start;
  logic [NS-1:0]  stg_ready;
  logic [NS-1:0]  stg_done;
  logic [CW-1:0]  last_lat;
  logic [NS*CW-1:0] stg_lat;

  typedef struct {int last; int s0; int s1;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int plan_l[NS];
  int plan_w[NS];
  int done_cyc;
  int start_cyc;
  int pend_val;
  bit pend = 1'b0;
  logic [NS-1:0] cur_en = '0;

  hls_stage_sequencer #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .stage_en(stage_en),
    .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle), .stg_start(stg_start),
    .stg_ready(stg_ready), .stg_done(stg_done), .last_lat(last_lat), .stg_lat(stg_lat)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Monitor: pops the scoreboard on every ap_done pulse; last_lat is due one cycle later
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (pend) begin
        check("last_lat", last_lat, pend_val);
        pend = 1'b0;
      end
      check("ready_eq_done", ap_ready, ap_done);
      if (stg_start != 0) begin
        check("start_onehot", $countones(stg_start), 1);
        check("start_masked", stg_start & ~cur_en, 0);
      end
      if (ap_done) begin
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("stg_lat0", stg_lat[0 +: CW], mon_e.s0);
          check("stg_lat1", stg_lat[CW +: CW], mon_e.s1);
          pend_val = mon_e.last;
          pend     = 1'b1;
        end
      end
    end
  end

  task automatic rand_plan();
    for (int i = 0; i < NS; i++) begin
      plan_l[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 20) : $urandom_range(1, 4);
      plan_w[i] = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4);
    end
  endtask

  task automatic drive_stray(input int cur);
    stg_ready = '0;
    stg_done  = '0;
    for (int j = 0; j < NS; j++) begin
      if (j != cur) begin
        stg_done[j]  = ($urandom_range(0, 3) == 0);
        stg_ready[j] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  // Issues one run following plan_l/plan_w; entered and left at a negedge
  task automatic do_run(input logic [NS-1:0] en, input bit hold);
    int   t;
    int   tot;
    exp_t e;
    logic [NS-1:0] oh;
    ap_start = 1'b1;
    stage_en = en;
    t = 0;
    while (!ap_idle && t < 100) begin
      @(negedge ap_clk);
      t++;
    end
    if (!ap_idle) check("idle_timeout", 0, 1);
    tot  = 1;
    e.s0 = 0;
    e.s1 = 0;
    if (en[0]) begin e.s0 = sat(plan_l[0] + plan_w[0]); tot += plan_l[0] + plan_w[0]; end
    if (en[1]) begin e.s1 = sat(plan_l[1] + plan_w[1]); tot += plan_l[1] + plan_w[1]; end
    e.last = sat(tot);
    sb.push_back(e);
    cur_en = en;
    @(posedge ap_clk);
    @(negedge ap_clk);
    if (!hold) ap_start = 1'b0;
    stage_en  = NS'($urandom);
    start_cyc = -1;
    for (int i = 0; i < NS; i++) begin
      if (en[i]) begin
        if (start_cyc < 0) start_cyc = cyc;
        oh = NS'(1) << i;
        for (int c = 1; c <= plan_l[i]; c++) begin
          check("start_in_launch", stg_start, oh);
          drive_stray(i);
          if (c == plan_l[i]) begin
            if (plan_w[i] == 0) begin
              stg_done[i]  = 1'b1;
              stg_ready[i] = 1'($urandom_range(0, 1));
            end else stg_ready[i] = 1'b1;
          end
          @(posedge ap_clk);
          @(negedge ap_clk);
        end
        for (int w = 1; w <= plan_w[i]; w++) begin
          check("start_low_in_wait", stg_start, 0);
          drive_stray(i);
          if (w == plan_w[i]) stg_done[i] = 1'b1;
          @(posedge ap_clk);
          @(negedge ap_clk);
        end
      end
    end
    stg_ready = '0;
    stg_done  = '0;
    check("done_timing", ap_done, 1);
    done_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d;
    ap_rst = 1'b1; ap_start = 1'b0; stage_en = '0; stg_ready = '0; stg_done = '0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_start", stg_start, 0);
    check("rst_last_lat", last_lat, 0);
    check("rst_stg_lat", stg_lat, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);

    // Nominal: stage0 done on 3rd launch cycle, stage1 ready then done on 2nd wait cycle
    plan_l = '{3, 1};
    plan_w = '{0, 2};
    do_run(2'b11, 1'b0);
    @(negedge ap_clk);
    check("t2_last_lat", last_lat, 7);

    // Reset during an active launch
    ap_start = 1'b1; stage_en = 2'b01; cur_en = 2'b01;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("t1_pre_start", stg_start, 2'b01);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("t1_idle", ap_idle, 1);
    check("t1_start", stg_start, 0);
    check("t1_done", ap_done, 0);
    check("t1_last_lat", last_lat, 0);
    check("t1_stg_lat", stg_lat, 0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);

    // Masks
    rand_plan();
    do_run(2'b10, 1'b0);
    do_run(2'b00, 1'b0);
    @(negedge ap_clk);
    check("t3_min_last_lat", last_lat, 1);

    // Back-to-back with ap_start held
    rand_plan();
    do_run(2'b01, 1'b1);
    d = done_cyc;
    rand_plan();
    do_run(2'b10, 1'b0);
    check("t4_b2b_gap", start_cyc - d, 2);

    // Saturation with stray stage1 handshakes while stage0 stalls
    plan_l = '{20, 2};
    plan_w = '{0, 1};
    do_run(2'b11, 1'b0);

    repeat (30) begin
      rand_plan();
      do_run(NS'($urandom), ($urandom_range(0, 3) == 0));
    end
    rand_plan();
    do_run(2'b11, 1'b0);

    repeat (3) @(negedge ap_clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
